// File: rtl/elbeth_data_mem_ctrl.sv
// rtl/elbeth_data_mem_ctrl.sv - data-memory request responder with lane steering and load extension
// Drives a word-wide variable-latency bus; flags misalignment, illegal sizes and bus timeouts.
module elbeth_data_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exs_mem_en,
  input  logic        exs_mem_rw,
  input  logic [3:0]  exs_data_size_mem,
  input  logic        exs_data_sign_mem,
  input  logic [31:0] exs_mem_addr,
  input  logic [31:0] exs_mem_wdata,
  output logic [31:0] exs_mem_rdata,
  output logic        exs_mem_ready,
  output logic        exs_mem_exception,
  output logic [1:0]  exs_mem_exc_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_byte_en,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0010;
  localparam logic [3:0] SZ_WORD = 4'b1000;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [3:0]  size_q;
  logic        sign_q;

  logic        req_active;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    req_active = exs_mem_en && (exs_data_size_mem != 4'b0000);
    illegal    = !((exs_data_size_mem == SZ_BYTE) || (exs_data_size_mem == SZ_HALF) ||
                   (exs_data_size_mem == SZ_WORD));
    misaligned = ((exs_data_size_mem == SZ_HALF) && exs_mem_addr[0]) ||
                 ((exs_data_size_mem == SZ_WORD) && (exs_mem_addr[1:0] != 2'b00));
    be_next    = 4'b1111;
    wdata_next = exs_mem_wdata;
    case (exs_data_size_mem)
      SZ_BYTE: begin
        be_next    = 4'b0001 << exs_mem_addr[1:0];
        wdata_next = {4{exs_mem_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_next    = 4'b0011 << {exs_mem_addr[1], 1'b0};
        wdata_next = {2{exs_mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extract the addressed lane from the bus word, then widen it.
  always_comb begin
    shifted  = dmem_rdata >> {lane_q, 3'b000};
    load_ext = dmem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = sign_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      SZ_HALF: load_ext = sign_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

  // Ready falls in the acceptance cycle itself so the pipeline stalls without a bubble.
  always_comb begin
    if (state == IDLE) exs_mem_ready = !req_active;
    else               exs_mem_ready = (state == DONE) || (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= 8'd0;
      lane_q            <= 2'b00;
      size_q            <= 4'b0000;
      sign_q            <= 1'b0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= 32'd0;
      dmem_byte_en      <= 4'b0000;
      dmem_wdata        <= 32'd0;
      exs_mem_rdata     <= 32'd0;
      exs_mem_exception <= 1'b0;
      exs_mem_exc_cause <= 2'b00;
    end else begin
      exs_mem_exception <= 1'b0;
      exs_mem_exc_cause <= 2'b00;
      case (state)
        IDLE: begin
          if (req_active) begin
            if (illegal) begin
              state             <= ERR;
              exs_mem_exception <= 1'b1;
              exs_mem_exc_cause <= 2'b11;
            end else if (misaligned) begin
              state             <= ERR;
              exs_mem_exception <= 1'b1;
              exs_mem_exc_cause <= 2'b01;
            end else begin
              state        <= REQ;
              wait_cnt     <= 8'd0;
              dmem_req     <= 1'b1;
              dmem_we      <= exs_mem_rw;
              dmem_addr    <= {exs_mem_addr[31:2], 2'b00};
              dmem_byte_en <= be_next;
              dmem_wdata   <= wdata_next;
              lane_q       <= exs_mem_addr[1:0];
              size_q       <= exs_data_size_mem;
              sign_q       <= exs_data_sign_mem;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) exs_mem_rdata <= load_ext;
          end else if (wait_cnt == WAIT_LAST) begin
            state             <= ERR;
            dmem_req          <= 1'b0;
            exs_mem_exception <= 1'b1;
            exs_mem_exc_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
